// File: rtl/fifo_traffic_engine.sv
// Driver-side FIFO traffic engine: pushes a pattern stream into a FIFO, pops it back
// and counts words whose read data differs from the regenerated pattern.
module fifo_traffic_engine #(
    parameter int              DW     = 8,
    parameter int              RD_LAT = 1,
    parameter logic [DW-1:0]   SEED   = {{(DW-1){1'b0}}, 1'b1},
    parameter int              CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_words,
    input  logic          mode,
    input  logic [1:0]    rd_gap,
    output logic          push,
    input  logic          full,
    output logic [DW-1:0] data_in,
    output logic          pop,
    input  logic          empty,
    input  logic [DW-1:0] data_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Galois right-shift toggle masks for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps32(input int w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            default: return 32'h0000_00B8;
        endcase
    endfunction

    localparam logic [31:0]   TAPS32    = lfsr_taps32(DW);
    localparam logic [DW-1:0] LFSR_TAPS = TAPS32[DW-1:0];

    function automatic logic [DW-1:0] next_pat(input logic m, input logic [DW-1:0] cur);
        if (m)
            return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
        return cur + DW'(1);
    endfunction

    state_t        state_q;
    logic [CW-1:0] num_q;
    logic          mode_q;
    logic [1:0]    gap_q;
    logic [1:0]    gap_cnt_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic [CW-1:0] err_cnt_q;
    logic [DW-1:0] wr_gen_q;
    logic [DW-1:0] rd_gen_q;
    logic [DW-1:0] wr_gen_d;
    logic [DW-1:0] rd_gen_d;

    logic          cmp_vld;
    logic [DW-1:0] cmp_exp;
    logic          cmp_err;
    logic          pipe_busy;

    assign wr_gen_d = next_pat(mode_q, wr_gen_q);
    assign rd_gen_d = next_pat(mode_q, rd_gen_q);

    assign push    = (state_q == RUN) && (wr_cnt_q < num_q) && !full;
    assign pop     = (state_q == RUN) && (rd_cnt_q < num_q) && !empty && (gap_cnt_q == 2'd0);
    assign data_in = (state_q == RUN) ? wr_gen_q : '0;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign err_cnt = err_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign rd_cnt  = rd_cnt_q;

    assign cmp_err = cmp_vld && (data_out != cmp_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            mode_q    <= 1'b0;
            gap_q     <= 2'd0;
            gap_cnt_q <= 2'd0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
            wr_gen_q  <= SEED;
            rd_gen_q  <= SEED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_q     <= num_words;
                        mode_q    <= mode;
                        gap_q     <= rd_gap;
                        gap_cnt_q <= 2'd0;
                        wr_cnt_q  <= '0;
                        rd_cnt_q  <= '0;
                        err_cnt_q <= '0;
                        wr_gen_q  <= SEED;
                        rd_gen_q  <= SEED;
                        state_q   <= (num_words == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        wr_cnt_q <= wr_cnt_q + CW'(1);
                        wr_gen_q <= wr_gen_d;
                    end
                    if (pop) begin
                        rd_cnt_q  <= rd_cnt_q + CW'(1);
                        gap_cnt_q <= gap_q;
                        rd_gen_q  <= rd_gen_d;
                    end else if (gap_cnt_q != 2'd0) begin
                        gap_cnt_q <= gap_cnt_q - 2'd1;
                    end
                    if (rd_cnt_q == num_q)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!pipe_busy)
                        state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
            // Compares only occur in RUN/DRAIN, so this never races the clear on start.
            if (cmp_err && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + CW'(1);
        end
    end

    // Expected-value pipeline aligned with the FIFO read latency.
    if (RD_LAT == 0) begin : g_lat0
        assign cmp_vld   = pop;
        assign cmp_exp   = rd_gen_q;
        assign pipe_busy = 1'b0;
    end else begin : g_pipe
        logic [DW-1:0]     exp_q [RD_LAT];
        logic [RD_LAT-1:0] vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < RD_LAT; i++)
                    exp_q[i] <= '0;
            end else begin
                vld_q[0] <= pop;
                exp_q[0] <= rd_gen_q;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    exp_q[i] <= exp_q[i-1];
                end
            end
        end

        assign cmp_vld   = vld_q[RD_LAT-1];
        assign cmp_exp   = exp_q[RD_LAT-1];
        assign pipe_busy = |vld_q;
    end

endmodule

// File: doc/fifo_traffic_engine.md
Name: fifo_traffic_engine

Overview:
- Active traffic engine on the driver side of the FIFO interface.
- Writes a programmable number of pattern words into the FIFO, honouring full.
- Pops the same number back, honouring empty and an optional read throttle, and checks every popped word against the regenerated pattern.
- Sits opposite the FIFO under test, in the bench or in a BIST wrapper, and reports completion, transfer counts and mismatch count.

Parameters:
- DW, 8: data width; must equal the width of fifo_pkg::data_t.
- RD_LAT, 1: cycles from pop asserted to data_out valid; legal range 0..3.
- SEED, 8'h01: pattern start value; must be non-zero for LFSR mode.
- CW, 16: width of num_words and of all counters.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle request to begin a run; ignored while busy.
- num_words, in, CW: words to transfer; latched on accepted start.
- mode, in, 1: pattern select; 0 = incrementing, 1 = LFSR. Latched on start.
- rd_gap, in, 2: idle cycles forced after each pop; latched on start.
- push, out, 1: FIFO push (fifo_pkg encoding: 1 = push).
- full, in, 1: FIFO full.
- data_in, out, DW: write data to FIFO.
- pop, out, 1: FIFO pop (1 = pop).
- empty, in, 1: FIFO empty.
- data_out, in, DW: read data from FIFO.
- busy, out, 1: run in progress.
- done, out, 1: one-cycle pulse at end of run.
- err_cnt, out, CW: mismatches in the last run, saturating.
- wr_cnt, out, CW: words pushed in the current/last run.
- rd_cnt, out, CW: words popped in the current/last run.

Behaviour:
- Reset (async): state IDLE; push=0, pop=0, data_in=0, busy=0, done=0, err_cnt=0, wr_cnt=0, rd_cnt=0, all generators = SEED, compare pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start: latch num_words, mode, rd_gap; clear all counters; load both generators with SEED.
- IDLE -> DONE on start when num_words==0; no push or pop is issued.
- RUN -> DRAIN when rd_cnt reaches num_words.
- DRAIN -> DONE when the compare pipeline holds no valid entries.
- DONE -> IDLE after one cycle; done=1 only in DONE.
- busy=1 in RUN and DRAIN.
- Write side, combinational: push = (state==RUN) && (wr_cnt<num_words) && !full.
  - data_in = wr_gen, a register.
  - On push: wr_cnt++ and wr_gen advances.
  - Full is honoured in the same cycle; push is never asserted while full=1.
- Read side, combinational: pop = (state==RUN) && (rd_cnt<num_words) && !empty && (gap_cnt==0).
  - On pop: rd_cnt++, gap_cnt loads rd_gap, rd_gen advances, and the current rd_gen value enters an expected-value pipeline of depth RD_LAT with a valid bit.
  - gap_cnt decrements to 0 on non-pop cycles.
- Push and pop may be asserted in the same cycle; the two sides are independent.
- Compare: when a pipeline entry emerges valid, data_out is compared with the expected value. With RD_LAT=0 the compare happens in the pop cycle.
  - On mismatch, err_cnt increments; it saturates at all-ones.
- Incrementing pattern: next = cur + 1 mod 2^DW; wraps all-ones -> 0.
- LFSR pattern: Galois, maximal-length for DW, never reaches 0.
  - The DW=8 polynomial is x^8+x^6+x^5+x^4+1 (taps 8'hB8, shift right).
- start while busy: ignored; latched values do not change.
- rst mid-run: everything returns to reset values immediately; no done pulse.
- Counters and err_cnt hold after DONE until the next accepted start.

Test Plan:
- Smoke, ideal FIFO (depth 16, RD_LAT=1), start with num_words=10, mode=0, rd_gap=0 -> data_in sequence 01..0A; rd_cnt=10; err_cnt=0; one done pulse; busy low the cycle after done.
- Full back-pressure: depth-4 FIFO, rd_gap=3, num_words=20 -> push never high while full=1; wr_cnt=rd_cnt=20; err_cnt=0.
- Wrap/LFSR: mode=0, num_words=300 -> data_in wraps FF->00 with no errors. Mode=1, num_words=255 -> 255 distinct non-zero values; err_cnt=0.
- Error injection: model corrupts words 3 and 7 (bit 0 flipped) -> err_cnt=2 at done.
- Corner cases:
  - num_words=0 -> done pulses the cycle after start, with push=pop=0 throughout.
  - start asserted during RUN -> ignored.
- Reset mid-run: assert rst after 5 pushes -> push, pop, busy and all counters are 0 in the same cycle. A new start then completes normally.
